demux1_2_buf: RTL and testbench

- Buffered 1-to-2 demultiplexer: the inverse of the 2:1 datapath select mux.
- A single 32-bit input stream with a per-word select `s` is steered to one of two output streams.
- Each output has its own small FIFO with a valid/ready handshake.
- Used to route write-back/result words to two consumers (e.g. a register-file port and a store/debug path) without stalling the other consumer.

---
 rtl/demux1_2_buf.sv | 107 ++++++++++
 tb/tb_demux1_2_buf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 demultiplexer: each input word is steered by `s` into one of two
// small FIFOs. Optional per-output push statistics are enabled by DEMUX1_2_BUF_STATS_EN.
module demux1_2_buf #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready,
`ifdef DEMUX1_2_BUF_STATS_EN
    output logic [15:0]      stat1,
    output logic [15:0]      stat2,
`endif
    output logic [CW-1:0]    count1,
    output logic [CW-1:0]    count2
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [PW-1:0]    wr1, rd1, wr2, rd2;
    logic [CW-1:0]    cnt1, cnt2;
    logic             full1, full2;
    logic             push1, push2, pop1, pop2;

    // Readiness looks only at occupancy: a full FIFO refuses even while it pops.
    assign full1    = (cnt1 == CW'(DEPTH));
    assign full2    = (cnt2 == CW'(DEPTH));
    assign in_ready = s ? !full2 : !full1;

    assign push1 = in_valid && in_ready && !s;
    assign push2 = in_valid && in_ready && s;
    assign pop1  = out1_valid && out1_ready;
    assign pop2  = out2_valid && out2_ready;

    assign out1       = mem1[rd1];
    assign out2       = mem2[rd2];
    assign out1_valid = (cnt1 != '0);
    assign out2_valid = (cnt2 != '0);
    assign count1     = cnt1;
    assign count2     = cnt2;

    // Storage is cleared on reset so a discarded word can never resurface at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem1[i] <= '0;
            wr1  <= '0;
            rd1  <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) begin
                mem1[wr1] <= in;
                wr1       <= wr1 + 1'b1;
            end
            if (pop1) rd1 <= rd1 + 1'b1;
            case ({push1, pop1})
                2'b10:   cnt1 <= cnt1 + 1'b1;
                2'b01:   cnt1 <= cnt1 - 1'b1;
                default: cnt1 <= cnt1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem2[i] <= '0;
            wr2  <= '0;
            rd2  <= '0;
            cnt2 <= '0;
        end else begin
            if (push2) begin
                mem2[wr2] <= in;
                wr2       <= wr2 + 1'b1;
            end
            if (pop2) rd2 <= rd2 + 1'b1;
            case ({push2, pop2})
                2'b10:   cnt2 <= cnt2 + 1'b1;
                2'b01:   cnt2 <= cnt2 - 1'b1;
                default: cnt2 <= cnt2;
            endcase
        end
    end

`ifdef DEMUX1_2_BUF_STATS_EN
    // Saturating counters of accepted pushes per output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat1 <= '0;
            stat2 <= '0;
        end else begin
            if (push1 && (stat1 != 16'hFFFF)) stat1 <= stat1 + 16'd1;
            if (push2 && (stat2 != 16'hFFFF)) stat2 <= stat2 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1_2_buf.sv
// Directed bench for demux1_2_buf: routing, full/refuse, push+pop, async reset and,
// when DEMUX1_2_BUF_STATS_EN is defined, the saturating push statistics.
module tb_demux1_2_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in;
    logic        s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1, out2;
    logic        out1_valid, out2_valid;
    logic        out1_ready, out2_ready;
    logic [1:0]  count1, count2;
`ifdef DEMUX1_2_BUF_STATS_EN
    logic [15:0] stat1, stat2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux1_2_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .s          (s),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2       (out2),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
`ifdef DEMUX1_2_BUF_STATS_EN
        .stat1      (stat1),
        .stat2      (stat2),
`endif
        .count1     (count1),
        .count2     (count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [31:0] data);
        s        = sel;
        in       = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in         = '0;
        s          = 1'b0;
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        tick();
        tick();
        chk("rst_out1_valid", 32'(out1_valid), 0);
        chk("rst_out2_valid", 32'(out2_valid), 0);
        chk("rst_count1", 32'(count1), 0);
        chk("rst_count2", 32'(count2), 0);
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        rst_n = 1'b1;
        tick();

        // Single word to out1, consumer stalled.
        chk("empty_in_ready", 32'(in_ready), 1);
        push(1'b0, 32'h0200F00F);
        chk("t1_out1", out1, 32'h0200F00F);
        chk("t1_out1_valid", 32'(out1_valid), 1);
        chk("t1_count1", 32'(count1), 1);
        chk("t1_out2_valid", 32'(out2_valid), 0);

        // Single word to out2 with consumer ready: visible for exactly one cycle.
        out2_ready = 1'b1;
        push(1'b1, 32'h20F00200);
        chk("t2_out2", out2, 32'h20F00200);
        chk("t2_out2_valid", 32'(out2_valid), 1);
        chk("t2_count2", 32'(count2), 1);
        tick();
        chk("t2_out2_valid_gone", 32'(out2_valid), 0);
        chk("t2_count2_zero", 32'(count2), 0);
        out2_ready = 1'b0;

        // Drain out1, then fill it beyond capacity.
        out1_ready = 1'b1;
        tick();
        chk("drain_count1", 32'(count1), 0);
        out1_ready = 1'b0;
        push(1'b0, 32'hA1A1A1A1);
        push(1'b0, 32'hA2A2A2A2);
        chk("fill_count1", 32'(count1), 2);
        s  = 1'b0;
        in = 32'hA3A3A3A3;
        #1;
        chk("full_in_ready_s0", 32'(in_ready), 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_held_count1", 32'(count1), 2);
        s = 1'b1;
        #1;
        chk("full_in_ready_s1", 32'(in_ready), 1);
        out1_ready = 1'b1;
        chk("drain_first", out1, 32'hA1A1A1A1);
        tick();
        chk("drain_second", out1, 32'hA2A2A2A2);
        chk("drain_count_mid", 32'(count1), 1);
        tick();
        chk("drain_empty", 32'(out1_valid), 0);
        out1_ready = 1'b0;

        // Same-cycle push and pop with one word held.
        push(1'b0, 32'hB1B1B1B1);
        chk("pp_head_before", out1, 32'hB1B1B1B1);
        out1_ready = 1'b1;
        push(1'b0, 32'hB2B2B2B2);
        chk("pp_count1", 32'(count1), 1);
        chk("pp_head_after", out1, 32'hB2B2B2B2);
        out1_ready = 1'b0;

        // Full FIFO refuses a push even while popping.
        push(1'b0, 32'hB3B3B3B3);
        chk("full2_count1", 32'(count1), 2);
        out1_ready = 1'b1;
        s = 1'b0;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 0);
        push(1'b0, 32'hB4B4B4B4);
        chk("full_pop_count1", 32'(count1), 1);
        chk("full_pop_head", out1, 32'hB3B3B3B3);
        out1_ready = 1'b0;

        // Asynchronous reset between edges with both FIFOs holding data.
        push(1'b1, 32'hC1C1C1C1);
        chk("pre_rst_count2", 32'(count2), 1);
        chk("pre_rst_count1", 32'(count1), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out1_valid", 32'(out1_valid), 0);
        chk("arst_out2_valid", 32'(out2_valid), 0);
        chk("arst_count1", 32'(count1), 0);
        chk("arst_count2", 32'(count2), 0);
        tick();
        #3;
        rst_n = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_out1_valid", 32'(out1_valid), 0);
        chk("post_rst_out2_valid", 32'(out2_valid), 0);
        chk("post_rst_out1", out1, 0);
        chk("post_rst_out2", out2, 0);

`ifdef DEMUX1_2_BUF_STATS_EN
        chk("stat1_reset", 32'(stat1), 0);
        for (int i = 0; i < 5; i++) push(1'b0, 32'(i));
        for (int i = 0; i < 3; i++) push(1'b1, 32'(i));
        chk("stat1_five", 32'(stat1), 5);
        chk("stat2_three", 32'(stat2), 3);
        s        = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        in_valid = 1'b0;
        chk("stat1_saturate", 32'(stat1), 32'h0000FFFF);
        chk("stat2_untouched", 32'(stat2), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
